sd_nios2_attempt_timer_svc: RTL and testbench

- Avalon-MM master (initiator) that drives the interval-timer slave of the sd_nios2_attempt system in hardware, with no CPU involvement.
- Programs period and control, starts the timer continuous with interrupt enabled, and services each IRQ by clearing status.
- Counts ticks and, on request, performs the snapshot write/read sequence to return the live 32-bit count.
- Sits beside the timer and shares its clock and reset.

---
 rtl/sd_nios2_attempt_timer_svc.sv | 195 +++++++++++++++++++
 tb/tb_sd_nios2_attempt_timer_svc.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_nios2_attempt_timer_svc.sv
// Hardware Avalon-MM initiator for the interval timer: programs period/control,
// services each timeout IRQ and performs the snapshot write/read sequence on request.
module sd_nios2_attempt_timer_svc #(
  parameter int unsigned MIN_PERIOD   = 16,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [31:0] period_cycles,
  input  logic        snap_req,
  input  logic        irq_in,
  output logic [2:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [15:0] avm_writedata,
  input  logic [15:0] avm_readdata,
  output logic        running,
  output logic        tick,
  output logic [31:0] tick_count,
  output logic [31:0] snapshot,
  output logic        snap_valid
);

  localparam logic [31:0] MIN_P    = 32'(MIN_PERIOD);
  localparam logic [7:0]  WAIT_END = 8'(READ_LATENCY - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_PL, S_WR_PH, S_SETTLE, S_WR_CTRL, S_RUN, S_CLR, S_GUARD,
    S_SNAP_WR, S_SNAP_RL, S_WAIT_L, S_SNAP_RH, S_WAIT_H, S_STOP, S_STOP_CLR
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] load_q, load_d;
  logic [31:0] tick_count_q, tick_count_d;
  logic [31:0] snapshot_q, snapshot_d;
  logic [15:0] lo_q, lo_d;
  logic [7:0]  wait_q, wait_d;
  logic        pend_q, pend_d;
  logic        tick_q, tick_d;
  logic        snap_valid_q, snap_valid_d;
  logic        running_q, running_d;
  logic        cs_q, cs_d;
  logic        wn_q, wn_d;
  logic [2:0]  addr_q, addr_d;
  logic [15:0] wd_q, wd_d;
  logic        wait_done;

  assign wait_done = (wait_q == WAIT_END);

  // Next-state, datapath and tick/snapshot bookkeeping.
  always_comb begin
    state_d      = state_q;
    load_d       = load_q;
    tick_count_d = tick_count_q;
    snapshot_d   = snapshot_q;
    lo_d         = lo_q;
    wait_d       = 8'd0;
    pend_d       = pend_q;
    tick_d       = 1'b0;
    snap_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          load_d       = (period_cycles < MIN_P) ? (MIN_P - 32'd1) : (period_cycles - 32'd1);
          tick_count_d = 32'd0;
          state_d      = S_WR_PL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR_PL:   state_d = S_WR_PH;
      S_WR_PH:   state_d = S_SETTLE;
      S_SETTLE:  state_d = S_WR_CTRL;
      S_WR_CTRL: state_d = S_RUN;
      S_RUN: begin
        if (!enable) begin
          state_d = S_STOP;
        end else if (irq_in) begin
          state_d = S_CLR;
        end else if (pend_q) begin
          state_d = S_SNAP_WR;
        end else begin
          state_d = S_RUN;
        end
      end
      S_CLR:     state_d = S_GUARD;
      S_GUARD:   state_d = S_RUN;
      S_SNAP_WR: state_d = S_SNAP_RL;
      S_SNAP_RL: state_d = S_WAIT_L;
      S_WAIT_L: begin
        if (wait_done) begin
          lo_d    = avm_readdata;
          state_d = S_SNAP_RH;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_SNAP_RH: state_d = S_WAIT_H;
      S_WAIT_H: begin
        if (wait_done) begin
          snapshot_d   = {avm_readdata, lo_q};
          snap_valid_d = 1'b1;
          pend_d       = 1'b0;
          state_d      = S_RUN;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_STOP:     state_d = S_STOP_CLR;
      S_STOP_CLR: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    if (state_d == S_CLR) begin
      tick_d       = 1'b1;
      tick_count_d = tick_count_q + 32'd1;
    end else begin
      tick_d = 1'b0;
    end
    // A request arriving on the completion cycle is a fresh one, so set wins over clear.
    if (snap_req && (state_q != S_IDLE)) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_d;
    end
  end

  // Bus and status outputs decoded from the upcoming state so they register in step with it.
  always_comb begin
    cs_d      = 1'b0;
    wn_d      = 1'b1;
    addr_d    = 3'd0;
    wd_d      = 16'h0000;
    running_d = 1'b0;
    case (state_d)
      S_WR_PL:    begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd2; wd_d = load_d[15:0];  end
      S_WR_PH:    begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd3; wd_d = load_d[31:16]; end
      S_WR_CTRL:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wd_d = 16'h0007;      end
      S_CLR:      begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd0; running_d = 1'b1;     end
      S_SNAP_WR:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd4; running_d = 1'b1;     end
      S_SNAP_RL:  begin cs_d = 1'b1; addr_d = 3'd4; running_d = 1'b1;                  end
      S_SNAP_RH:  begin cs_d = 1'b1; addr_d = 3'd5; running_d = 1'b1;                  end
      S_STOP:     begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wd_d = 16'h0008;      end
      S_STOP_CLR: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd0;                       end
      S_RUN, S_GUARD, S_WAIT_L, S_WAIT_H: running_d = 1'b1;
      default:    running_d = 1'b0;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      load_q       <= 32'd0;
      tick_count_q <= 32'd0;
      snapshot_q   <= 32'd0;
      lo_q         <= 16'h0000;
      wait_q       <= 8'd0;
      pend_q       <= 1'b0;
      tick_q       <= 1'b0;
      snap_valid_q <= 1'b0;
      running_q    <= 1'b0;
      cs_q         <= 1'b0;
      wn_q         <= 1'b1;
      addr_q       <= 3'd0;
      wd_q         <= 16'h0000;
    end else begin
      state_q      <= state_d;
      load_q       <= load_d;
      tick_count_q <= tick_count_d;
      snapshot_q   <= snapshot_d;
      lo_q         <= lo_d;
      wait_q       <= wait_d;
      pend_q       <= pend_d;
      tick_q       <= tick_d;
      snap_valid_q <= snap_valid_d;
      running_q    <= running_d;
      cs_q         <= cs_d;
      wn_q         <= wn_d;
      addr_q       <= addr_d;
      wd_q         <= wd_d;
    end
  end

  assign avm_address    = addr_q;
  assign avm_chipselect = cs_q;
  assign avm_write_n    = wn_q;
  assign avm_writedata  = wd_q;
  assign running        = running_q;
  assign tick           = tick_q;
  assign tick_count     = tick_count_q;
  assign snapshot       = snapshot_q;
  assign snap_valid     = snap_valid_q;

endmodule

// File: tb/tb_sd_nios2_attempt_timer_svc.sv
// Directed bench for sd_nios2_attempt_timer_svc with a small interval-timer slave model.
module tb_sd_nios2_attempt_timer_svc;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [31:0] period_cycles;
  logic        snap_req;
  logic        irq_in;
  logic [2:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [15:0] avm_writedata;
  logic [15:0] avm_readdata;
  logic        running;
  logic        tick;
  logic [31:0] tick_count;
  logic [31:0] snapshot;
  logic        snap_valid;

  int checks = 0;
  int errors = 0;

  sd_nios2_attempt_timer_svc #(.MIN_PERIOD(16), .READ_LATENCY(1)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .period_cycles(period_cycles),
    .snap_req(snap_req), .irq_in(irq_in), .avm_address(avm_address),
    .avm_chipselect(avm_chipselect), .avm_write_n(avm_write_n),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .running(running), .tick(tick), .tick_count(tick_count),
    .snapshot(snapshot), .snap_valid(snap_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Timer slave model
  logic [31:0] m_per, m_cnt, m_snap, ovr_val;
  logic        m_run, m_ito, m_to, ovr_en, inject_to;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_per <= 32'd0; m_cnt <= 32'd0; m_snap <= 32'd0;
      m_run <= 1'b0; m_ito <= 1'b0; m_to <= 1'b0; avm_readdata <= 16'h0000;
    end else begin
      avm_readdata <= 16'h0000;
      if (avm_chipselect && avm_write_n) begin
        if (avm_address == 3'd4) avm_readdata <= m_snap[15:0];
        else if (avm_address == 3'd5) avm_readdata <= m_snap[31:16];
      end
      if (m_run) begin
        if (m_cnt == 32'd0) begin m_to <= 1'b1; m_cnt <= m_per; end
        else m_cnt <= m_cnt - 32'd1;
      end
      if (inject_to) m_to <= 1'b1;
      if (avm_chipselect && !avm_write_n) begin
        case (avm_address)
          3'd0: m_to <= 1'b0;
          3'd1: begin
            m_ito <= avm_writedata[0];
            if (avm_writedata[2]) begin m_run <= 1'b1; m_cnt <= m_per; end
            if (avm_writedata[3]) m_run <= 1'b0;
          end
          3'd2: m_per[15:0]  <= avm_writedata;
          3'd3: m_per[31:16] <= avm_writedata;
          3'd4: m_snap <= ovr_en ? ovr_val : m_cnt;
          default: ;
        endcase
      end
    end
  end
  assign irq_in = m_to & m_ito;

  // Bus / pulse monitor
  logic [19:0] log_q[$];
  int          tick_q[$];
  int          cyc = 0;
  int          sv_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (avm_chipselect) log_q.push_back({avm_write_n, avm_address, avm_writedata});
    if (tick) tick_q.push_back(cyc);
    if (snap_valid) sv_cnt <= sv_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // {cs, write_n, address, writedata} seen right now
  task automatic chk_bus(input string tag, input logic cs, input logic wn,
                         input logic [2:0] a, input logic [15:0] d);
    chk(tag, {11'd0, avm_chipselect, avm_write_n, avm_address, avm_writedata},
        {11'd0, cs, wn, a, d});
  endtask

  task automatic chk_log(input string tag, input int idx, input logic wn,
                         input logic [2:0] a, input logic [15:0] d);
    logic [31:0] obs;
    obs = (idx < log_q.size()) ? {12'd0, log_q[idx]} : 32'hDEAD_DEAD;
    chk(tag, obs, {12'd0, wn, a, d});
  endtask

  task automatic clear_log();
    @(posedge clk);
    log_q.delete();
    tick_q.delete();
    @(negedge clk);
  endtask

  task automatic wait_running(input string tag, input logic want, input int max_cyc);
    int n;
    n = 0;
    while (running !== want && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, running}, {31'd0, want});
  endtask

  function automatic int count_entries(input logic [19:0] e);
    int c;
    c = 0;
    foreach (log_q[i]) if (log_q[i] == e) c++;
    return c;
  endfunction

  initial begin
    int n, bad, sv0;
    reset_n = 1'b0; enable = 1'b0; period_cycles = 32'd0; snap_req = 1'b0;
    ovr_en = 1'b0; ovr_val = 32'd0; inject_to = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk_bus("rst_bus", 1'b0, 1'b1, 3'd0, 16'h0000);
    chk("rst_running", {31'd0, running}, 32'd0);
    chk("rst_tick_count", tick_count, 32'd0);
    chk("rst_snapshot", snapshot, 32'd0);
    chk("rst_pulses", {30'd0, tick, snap_valid}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Programming sequence for 50000 cycles
    period_cycles = 32'd50000; enable = 1'b1;
    @(negedge clk); chk_bus("prog_pl", 1'b1, 1'b0, 3'd2, 16'hC34F);
    @(negedge clk); chk_bus("prog_ph", 1'b1, 1'b0, 3'd3, 16'h0000);
    @(negedge clk); chk_bus("prog_settle", 1'b0, 1'b1, 3'd0, 16'h0000);
    @(negedge clk); chk_bus("prog_ctrl", 1'b1, 1'b0, 3'd1, 16'h0007);
    chk("prog_ctrl_running", {31'd0, running}, 32'd0);
    @(negedge clk); chk("run_running", {31'd0, running}, 32'd1);
    chk_bus("run_bus_idle", 1'b0, 1'b1, 3'd0, 16'h0000);
    enable = 1'b0;
    @(negedge clk); chk_bus("stop_ctrl", 1'b1, 1'b0, 3'd1, 16'h0008);
    @(negedge clk); chk_bus("stop_clr", 1'b1, 1'b0, 3'd0, 16'h0000);
    @(negedge clk); chk_bus("stop_idle", 1'b0, 1'b1, 3'd0, 16'h0000);
    chk("stop_running", {31'd0, running}, 32'd0);

    // Clamped period with 100 serviced timeouts
    clear_log();
    period_cycles = 32'd5; enable = 1'b1;
    wait_running("p16_run", 1'b1, 20);
    chk_log("p16_pl", 0, 1'b0, 3'd2, 16'h000F);
    chk_log("p16_ph", 1, 1'b0, 3'd3, 16'h0000);
    n = 0;
    while (tick_count != 32'd100 && n < 2500) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("ticks_100", tick_count, 32'd100);
    chk("clr_writes_100", count_entries({1'b0, 3'd0, 16'h0000}), 32'd100);
    chk("tick_pulses_100", tick_q.size(), 32'd100);
    bad = 0;
    for (int i = 1; i < tick_q.size(); i++) if (tick_q[i] - tick_q[i-1] != 16) bad++;
    chk("tick_spacing_16", bad, 32'd0);
    enable = 1'b0;
    wait_running("p16_stop", 1'b0, 20);
    repeat (4) @(negedge clk);
    chk("ticks_retained", tick_count, 32'd100);

    // snap_req in IDLE is ignored; programming clears tick_count
    clear_log();
    snap_req = 1'b1; @(negedge clk); snap_req = 1'b0;
    repeat (3) @(negedge clk);
    period_cycles = 32'd50000; enable = 1'b1;
    wait_running("snap_run", 1'b1, 20);
    repeat (5) @(negedge clk);
    chk("idle_snap_ignored", log_q.size(), 32'd3);
    chk("ticks_cleared", tick_count, 32'd0);

    // Snapshot of 0x00012345
    clear_log();
    ovr_en = 1'b1; ovr_val = 32'h0001_2345; sv0 = sv_cnt;
    snap_req = 1'b1; @(negedge clk); snap_req = 1'b0;
    repeat (12) @(negedge clk);
    chk("snap_n_xfers", log_q.size(), 32'd3);
    chk_log("snap_wr4", 0, 1'b0, 3'd4, 16'h0000);
    chk_log("snap_rd4", 1, 1'b1, 3'd4, 16'h0000);
    chk_log("snap_rd5", 2, 1'b1, 3'd5, 16'h0000);
    chk("snap_value", snapshot, 32'h0001_2345);
    chk("snap_valid_once", sv_cnt - sv0, 32'd1);

    // irq and snap_req in the same RUN cycle: CLR first
    clear_log();
    ovr_val = 32'hBEEF_0042; sv0 = sv_cnt;
    inject_to = 1'b1; @(negedge clk); inject_to = 1'b0;
    snap_req = 1'b1; @(negedge clk); snap_req = 1'b0;
    repeat (14) @(negedge clk);
    chk("both_n_xfers", log_q.size(), 32'd4);
    chk_log("both_clr_first", 0, 1'b0, 3'd0, 16'h0000);
    chk_log("both_wr4", 1, 1'b0, 3'd4, 16'h0000);
    chk_log("both_rd4", 2, 1'b1, 3'd4, 16'h0000);
    chk_log("both_rd5", 3, 1'b1, 3'd5, 16'h0000);
    chk("both_tick_count", tick_count, 32'd1);
    chk("both_snapshot", snapshot, 32'hBEEF_0042);
    chk("both_snap_valid", sv_cnt - sv0, 32'd1);

    // enable dropped mid-snapshot
    clear_log();
    ovr_val = 32'h1234_5678; sv0 = sv_cnt;
    snap_req = 1'b1; @(negedge clk); snap_req = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b0;
    wait_running("mid_stop", 1'b0, 30);
    repeat (4) @(negedge clk);
    chk("mid_n_xfers", log_q.size(), 32'd5);
    chk_log("mid_wr4", 0, 1'b0, 3'd4, 16'h0000);
    chk_log("mid_rd4", 1, 1'b1, 3'd4, 16'h0000);
    chk_log("mid_rd5", 2, 1'b1, 3'd5, 16'h0000);
    chk_log("mid_stop_ctrl", 3, 1'b0, 3'd1, 16'h0008);
    chk_log("mid_stop_clr", 4, 1'b0, 3'd0, 16'h0000);
    chk("mid_snapshot", snapshot, 32'h1234_5678);
    chk("mid_snap_valid", sv_cnt - sv0, 32'd1);
    chk("mid_ticks_retained", tick_count, 32'd1);

    // Synchronous reset in the middle of WR_PH
    period_cycles = 32'd100; enable = 1'b1;
    @(negedge clk); chk_bus("rst2_pl", 1'b1, 1'b0, 3'd2, 16'h0063);
    @(negedge clk); chk_bus("rst2_ph", 1'b1, 1'b0, 3'd3, 16'h0000);
    reset_n = 1'b0; enable = 1'b0;
    @(negedge clk); chk_bus("rst2_bus_idle", 1'b0, 1'b1, 3'd0, 16'h0000);
    chk("rst2_tick_count", tick_count, 32'd0);
    chk("rst2_running", {31'd0, running}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
